sprite_pos_ctl: RTL and testbench



---
 rtl/sprite_pkg.sv | 32 +++
 rtl/sprite_pos_ctl_vblnk_edge.sv | 22 ++
 rtl/sprite_pos_ctl.sv | 109 ++++++++++
 tb/tb_sprite_pos_ctl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite position controller.
// Clamp limits keep a 128x128 sprite fully inside the 800x600 active area.
package sprite_pkg;

  localparam int COORD_W     = 11;
  localparam int FRAME_CNT_W = 16;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int SPRITE_W = 128;
  localparam int SPRITE_H = 128;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - SPRITE_W);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - SPRITE_H);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               vis;
  } pos_t;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sprite_pos_ctl_vblnk_edge.sv
// Registered rising-edge detector for vertical blanking.
// The history flop resets high so blanking already asserted at reset release is not an edge.
module vblnk_edge (
  input  logic pclk,
  input  logic rst,
  input  logic vblnk_in,
  output logic vb_edge
);

  logic vblnk_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_q <= 1'b1;
    end else begin
      vblnk_q <= vblnk_in;
    end
  end

  assign vb_edge = vblnk_in & ~vblnk_q;

endmodule

// File: rtl/sprite_pos_ctl.sv
// Frame-synchronous sprite position/visibility commit with frame counter.
// Optional build macro SPRITE_CLAMP_EN clamps latched coordinates to keep the sprite on screen.
//
//   state      | meaning
//   -----------+---------------------------------------------
//   ST_IDLE    | nothing waiting to be committed
//   ST_PENDING | one update held in pend_q, committed on vblank rise
module sprite_pos_ctl
  import sprite_pkg::*;
(
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   vblnk_in,
  input  logic                   pos_req,
  input  logic [COORD_W-1:0]     pos_x_req,
  input  logic [COORD_W-1:0]     pos_y_req,
  input  logic                   vis_req,
  output logic                   pos_ack,
  output logic [COORD_W-1:0]     xpos,
  output logic [COORD_W-1:0]     ypos,
  output logic                   visible,
  output logic                   pending,
  output logic                   frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

`ifdef SPRITE_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  state_t                 state_q, state_d;
  pos_t                   pend_q, pend_d;
  pos_t                   commit_q, commit_d;
  pos_t                   req_pos;
  logic                   ack_q, ack_d;
  logic                   tick_q, tick_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   vb_edge;

  vblnk_edge u_vblnk_edge (
    .pclk     (pclk),
    .rst      (rst),
    .vblnk_in (vblnk_in),
    .vb_edge  (vb_edge)
  );

  always_comb begin
    req_pos.x   = CLAMP_EN ? clamp_coord(pos_x_req, X_MAX) : pos_x_req;
    req_pos.y   = CLAMP_EN ? clamp_coord(pos_y_req, Y_MAX) : pos_y_req;
    req_pos.vis = vis_req;
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    commit_d = commit_q;
    ack_d    = 1'b0;
    tick_d   = 1'b0;
    cnt_d    = cnt_q;

    if (pos_req) begin
      pend_d  = req_pos;
      ack_d   = 1'b1;
      state_d = ST_PENDING;
    end

    // A request arriving on the edge itself bypasses the pend stage.
    if (vb_edge) begin
      tick_d = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      if (pos_req) begin
        commit_d = req_pos;
        state_d  = ST_IDLE;
      end else if (state_q == ST_PENDING) begin
        commit_d = pend_q;
        state_d  = ST_IDLE;
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      commit_q <= '0;
      ack_q    <= 1'b0;
      tick_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
      ack_q    <= ack_d;
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pos_ack    = ack_q;
  assign xpos       = commit_q.x;
  assign ypos       = commit_q.y;
  assign visible    = commit_q.vis;
  assign pending    = (state_q == ST_PENDING);
  assign frame_tick = tick_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_sprite_pos_ctl.sv
// Self-checking bench for sprite_pos_ctl: vector table through a scoreboard queue,
// plus reset-discard and frame-counter wrap sequences.
module tb_sprite_pos_ctl;

`ifdef SPRITE_CLAMP_EN
  localparam logic [10:0] CX = 11'd672;
  localparam logic [10:0] CY = 11'd472;
`else
  localparam logic [10:0] CX = 11'd790;
  localparam logic [10:0] CY = 11'd590;
`endif

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk_in;
  logic        pos_req;
  logic [10:0] pos_x_req;
  logic [10:0] pos_y_req;
  logic        vis_req;
  logic        pos_ack;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        visible;
  logic        pending;
  logic        frame_tick;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  sprite_pos_ctl dut (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk_in   (vblnk_in),
    .pos_req    (pos_req),
    .pos_x_req  (pos_x_req),
    .pos_y_req  (pos_y_req),
    .vis_req    (vis_req),
    .pos_ack    (pos_ack),
    .xpos       (xpos),
    .ypos       (ypos),
    .visible    (visible),
    .pending    (pending),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    string       name;
    logic        req;
    logic [10:0] x;
    logic [10:0] y;
    logic        vis;
    logic        vb;
    logic        e_ack;
    logic [10:0] e_x;
    logic [10:0] e_y;
    logic        e_vis;
    logic        e_pend;
    logic        e_tick;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string n, logic req, logic [10:0] x, logic [10:0] y, logic vis,
                              logic vb, logic e_ack, logic [10:0] e_x, logic [10:0] e_y,
                              logic e_vis, logic e_pend, logic e_tick, logic [15:0] e_cnt);
    vec_t v;
    v.name = n; v.req = req; v.x = x; v.y = y; v.vis = vis; v.vb = vb;
    v.e_ack = e_ack; v.e_x = e_x; v.e_y = e_y; v.e_vis = e_vis;
    v.e_pend = e_pend; v.e_tick = e_tick; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(vec_t v);
    vec_t e;
    pos_req   = v.req;
    pos_x_req = v.x;
    pos_y_req = v.y;
    vis_req   = v.vis;
    vblnk_in  = v.vb;
    sb.push_back(v);
    @(posedge pclk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".ack"},  16'(pos_ack),    16'(e.e_ack));
    chk({e.name, ".x"},    16'(xpos),       16'(e.e_x));
    chk({e.name, ".y"},    16'(ypos),       16'(e.e_y));
    chk({e.name, ".vis"},  16'(visible),    16'(e.e_vis));
    chk({e.name, ".pend"}, 16'(pending),    16'(e.e_pend));
    chk({e.name, ".tick"}, 16'(frame_tick), 16'(e.e_tick));
    chk({e.name, ".cnt"},  frame_cnt,       e.e_cnt);
  endtask

  task automatic chk_all_zero(string n);
    chk({n, ".ack"},  16'(pos_ack),    16'd0);
    chk({n, ".x"},    16'(xpos),       16'd0);
    chk({n, ".y"},    16'(ypos),       16'd0);
    chk({n, ".vis"},  16'(visible),    16'd0);
    chk({n, ".pend"}, 16'(pending),    16'd0);
    chk({n, ".tick"}, 16'(frame_tick), 16'd0);
    chk({n, ".cnt"},  frame_cnt,       16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            name       req x    y    vis vb  ack ex   ey   ev pend tick cnt
    tbl.push_back(mk("rel",    0, 0,   0,   0,  1,  0,  0,   0,   0, 0,   0,   0));
    tbl.push_back(mk("lo0",    0, 0,   0,   0,  0,  0,  0,   0,   0, 0,   0,   0));
    tbl.push_back(mk("req1",   1, 300, 200, 1,  0,  1,  0,   0,   0, 1,   0,   0));
    tbl.push_back(mk("hold1",  0, 0,   0,   0,  0,  0,  0,   0,   0, 1,   0,   0));
    tbl.push_back(mk("edge1",  0, 0,   0,   0,  1,  0,  300, 200, 1, 0,   1,   1));
    tbl.push_back(mk("vbhi1",  0, 0,   0,   0,  1,  0,  300, 200, 1, 0,   0,   1));
    tbl.push_back(mk("lo1",    0, 0,   0,   0,  0,  0,  300, 200, 1, 0,   0,   1));
    tbl.push_back(mk("reqa",   1, 10,  10,  0,  0,  1,  300, 200, 1, 1,   0,   1));
    tbl.push_back(mk("reqb",   1, 50,  60,  1,  0,  1,  300, 200, 1, 1,   0,   1));
    tbl.push_back(mk("hold2",  0, 0,   0,   0,  0,  0,  300, 200, 1, 1,   0,   1));
    tbl.push_back(mk("edge2",  0, 0,   0,   0,  1,  0,  50,  60,  1, 0,   1,   2));
    tbl.push_back(mk("lo2",    0, 0,   0,   0,  0,  0,  50,  60,  1, 0,   0,   2));
    tbl.push_back(mk("simul",  1, 5,   7,   0,  1,  1,  5,   7,   0, 0,   1,   3));
    tbl.push_back(mk("lo3",    0, 0,   0,   0,  0,  0,  5,   7,   0, 0,   0,   3));
    tbl.push_back(mk("reqc",   1, 790, 590, 1,  0,  1,  5,   7,   0, 1,   0,   3));
    tbl.push_back(mk("edgec",  0, 0,   0,   0,  1,  0,  CX,  CY,  1, 0,   1,   4));
    tbl.push_back(mk("lo4",    0, 0,   0,   0,  0,  0,  CX,  CY,  1, 0,   0,   4));
    tbl.push_back(mk("edgeid", 0, 0,   0,   0,  1,  0,  CX,  CY,  1, 0,   1,   5));
    tbl.push_back(mk("lo5",    0, 0,   0,   0,  0,  0,  CX,  CY,  1, 0,   0,   5));
    tbl.push_back(mk("reqlim", 1, 672, 472, 0,  0,  1,  CX,  CY,  1, 1,   0,   5));
    tbl.push_back(mk("edgelm", 0, 0,   0,   0,  1,  0,  672, 472, 0, 0,   1,   6));
    tbl.push_back(mk("lo6",    0, 0,   0,   0,  0,  0,  672, 472, 0, 0,   0,   6));
    tbl.push_back(mk("held0",  1, 1,   2,   1,  0,  1,  672, 472, 0, 1,   0,   6));
    tbl.push_back(mk("held1",  1, 1,   2,   1,  0,  1,  672, 472, 0, 1,   0,   6));
    tbl.push_back(mk("drop",   0, 0,   0,   0,  0,  0,  672, 472, 0, 1,   0,   6));

    rst = 1'b1; vblnk_in = 1'b1; pos_req = 1'b0;
    pos_x_req = '0; pos_y_req = '0; vis_req = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk_all_zero("in_reset");
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset while an update is pending: it must be discarded.
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(posedge pclk);
    #1;
    rst = 1'b0;
    apply(mk("rlo",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("redge", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    apply(mk("rlo2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Preload the counter near wrap instead of running 65535 frames.
    force dut.cnt_q = 16'hFFFE;
    @(posedge pclk);
    #1;
    release dut.cnt_q;
    apply(mk("wlo",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFE));
    apply(mk("wedge1", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'hFFFF));
    apply(mk("wlo2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF));
    apply(mk("wrap",   0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0000));
    apply(mk("wlo3",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
